// File: rtl/ones_frame_accumulator.sv
// Sums per-byte ones counts over a framed burst and holds the frame total,
// beat count and status flags on a valid/ready result handshake.
module ones_frame_accumulator #(
  parameter  int SUM_W     = 12,
  parameter  int MAX_BYTES = 256,
  parameter  int THRESH    = 1024,
  localparam int BC_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_valid,
  input  logic [3:0]       cnt_in,
  input  logic             cnt_last,
  output logic             cnt_ready,
  output logic             sum_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum_out,
  output logic [BC_W-1:0]  beat_cnt,
  output logic             over_thresh,
  output logic             sat,
  output logic             trunc,
  output logic             range_err
);

  // state | meaning
  // ACCUM | collecting beats of the current frame
  // DONE  | holding the frame result until out_ready
  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  localparam logic [SUM_W:0]    SUM_MAX  = {1'b0, {SUM_W{1'b1}}};
  localparam logic [BC_W-1:0]   MAX_BC   = BC_W'(MAX_BYTES);
  localparam logic [31:0]       THRESH_U = 32'(THRESH);

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [BC_W-1:0]  beat_q, beat_d;
  logic             over_q, over_d;
  logic             sat_q, sat_d;
  logic             trunc_q, trunc_d;
  logic             rerr_q, rerr_d;
  logic [SUM_W:0]   sum_ext;
  logic             accept;

  assign accept  = cnt_valid && ready_q && (state_q == ACCUM);
  assign sum_ext = {1'b0, sum_q} + {{(SUM_W - 3){1'b0}}, cnt_in};

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    beat_d  = beat_q;
    over_d  = over_q;
    sat_d   = sat_q;
    trunc_d = trunc_q;
    rerr_d  = rerr_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (sum_ext > SUM_MAX) begin
            sum_d = '1;
            sat_d = 1'b1;
          end else begin
            sum_d = sum_ext[SUM_W-1:0];
          end
          if (cnt_in > 4'd8) rerr_d = 1'b1;
          beat_d = beat_q + 1'b1;
          // MAX_BYTES closes the frame even without cnt_last
          if (cnt_last || (beat_d == MAX_BC)) begin
            state_d = DONE;
            valid_d = 1'b1;
            trunc_d = !cnt_last;
            over_d  = ({{(32 - SUM_W){1'b0}}, sum_d} >= THRESH_U);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
          valid_d = 1'b0;
          sum_d   = '0;
          beat_d  = '0;
          over_d  = 1'b0;
          sat_d   = 1'b0;
          trunc_d = 1'b0;
          rerr_d  = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
    // Registered so cnt_ready reads 0 while reset is held
    ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      beat_q  <= '0;
      over_q  <= 1'b0;
      sat_q   <= 1'b0;
      trunc_q <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      beat_q  <= beat_d;
      over_q  <= over_d;
      sat_q   <= sat_d;
      trunc_q <= trunc_d;
      rerr_q  <= rerr_d;
    end
  end

  assign cnt_ready   = ready_q;
  assign sum_valid   = valid_q;
  assign sum_out     = sum_q;
  assign beat_cnt    = beat_q;
  assign over_thresh = over_q;
  assign sat         = sat_q;
  assign trunc       = trunc_q;
  assign range_err   = rerr_q;

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed bench for ones_frame_accumulator: a default instance and a narrow
// 6-bit-total instance share the same stimulus.
module tb_ones_frame_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_valid;
  logic [3:0]  cnt_in;
  logic        cnt_last;
  logic        out_ready;

  logic        a_cnt_ready, a_sum_valid, a_over, a_sat, a_trunc, a_rerr;
  logic [11:0] a_sum;
  logic [8:0]  a_bc;
  logic        b_cnt_ready, b_sum_valid, b_over, b_sat, b_trunc, b_rerr;
  logic [5:0]  b_sum;
  logic [8:0]  b_bc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ones_frame_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .cnt_valid(cnt_valid), .cnt_in(cnt_in),
    .cnt_last(cnt_last), .cnt_ready(a_cnt_ready), .sum_valid(a_sum_valid),
    .out_ready(out_ready), .sum_out(a_sum), .beat_cnt(a_bc),
    .over_thresh(a_over), .sat(a_sat), .trunc(a_trunc), .range_err(a_rerr)
  );

  ones_frame_accumulator #(.SUM_W(6), .MAX_BYTES(256), .THRESH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .cnt_valid(cnt_valid), .cnt_in(cnt_in),
    .cnt_last(cnt_last), .cnt_ready(b_cnt_ready), .sum_valid(b_sum_valid),
    .out_ready(out_ready), .sum_out(b_sum), .beat_cnt(b_bc),
    .over_thresh(b_over), .sat(b_sat), .trunc(b_trunc), .range_err(b_rerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] c, input logic l);
    cnt_valid = 1'b1;
    cnt_in    = c;
    cnt_last  = l;
    @(posedge clk);
    #1;
    cnt_valid = 1'b0;
    cnt_in    = 4'd0;
    cnt_last  = 1'b0;
  endtask

  task automatic beats(input int n, input logic [3:0] c);
    for (int i = 0; i < n; i++) beat(c, 1'b0);
  endtask

  task automatic chk_a(input string tag, input logic [31:0] s, input logic [31:0] bc,
                       input logic o, input logic st, input logic tr, input logic re);
    chk({tag, ".valid"}, a_sum_valid, 1);
    chk({tag, ".sum"}, a_sum, s);
    chk({tag, ".beats"}, a_bc, bc);
    chk({tag, ".over"}, a_over, o);
    chk({tag, ".sat"}, a_sat, st);
    chk({tag, ".trunc"}, a_trunc, tr);
    chk({tag, ".rerr"}, a_rerr, re);
    chk({tag, ".ready"}, a_cnt_ready, 0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".hs_valid"}, a_sum_valid, 0);
    chk({tag, ".hs_sum"}, a_sum, 0);
    chk({tag, ".hs_beats"}, a_bc, 0);
    chk({tag, ".hs_flags"}, {a_over, a_sat, a_trunc, a_rerr}, 0);
    chk({tag, ".hs_ready"}, a_cnt_ready, 1);
    chk({tag, ".hs_b_valid"}, b_sum_valid, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cnt_valid = 1'b0; cnt_in = 4'd0; cnt_last = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst.ready", a_cnt_ready, 0);
    chk("rst.valid", a_sum_valid, 0);
    chk("rst.sum", a_sum, 0);
    release_reset();
    chk("rel.ready", a_cnt_ready, 1);

    // basic frame, out_ready high throughout accumulation
    out_ready = 1'b1;
    beat(4'd8, 1'b0); beat(4'd3, 1'b0); beat(4'd0, 1'b0);
    chk("f1.valid_early", a_sum_valid, 0);
    beat(4'd5, 1'b1);
    chk_a("f1", 16, 4, 0, 0, 0, 0);
    chk("f1.b_sum", b_sum, 16);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("f1.clr_valid", a_sum_valid, 0);
    chk("f1.clr_sum", a_sum, 0);
    chk("f1.clr_ready", a_cnt_ready, 1);

    // reset mid-frame
    beat(4'd8, 1'b0); beat(4'd8, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid.sum", a_sum, 0);
    chk("rmid.beats", a_bc, 0);
    chk("rmid.ready", a_cnt_ready, 0);
    chk("rmid.valid", a_sum_valid, 0);
    release_reset();
    beat(4'd3, 1'b1);
    chk_a("rmid_after", 3, 1, 0, 0, 0, 0);

    // reset while holding a result
    #2 rst_n = 1'b0;
    #1;
    chk("rdone.valid", a_sum_valid, 0);
    chk("rdone.sum", a_sum, 0);
    chk("rdone.b_valid", b_sum_valid, 0);
    release_reset();

    // backpressure: result held, beats ignored
    beat(4'd4, 1'b0); beat(4'd6, 1'b1);
    chk_a("bp", 10, 2, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cnt_valid = 1'b1; cnt_in = 4'd8; cnt_last = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.hold_valid", a_sum_valid, 1);
      chk("bp.hold_sum", a_sum, 10);
      chk("bp.hold_beats", a_bc, 2);
      chk("bp.hold_ready", a_cnt_ready, 0);
    end
    cnt_valid = 1'b0; cnt_last = 1'b0; cnt_in = 4'd0;
    handshake("bp");

    // back-to-back frames with single-beat second frame
    beat(4'd1, 1'b1);
    chk_a("b2b1", 1, 1, 0, 0, 0, 0);
    handshake("b2b1");
    beat(4'd7, 1'b1);
    chk_a("b2b2", 7, 1, 0, 0, 0, 0);
    handshake("b2b2");

    // zero-ones frame
    beat(4'd0, 1'b0); beat(4'd0, 1'b1);
    chk_a("zero", 0, 2, 0, 0, 0, 0);
    handshake("zero");

    // out-of-range count is added as-is
    beat(4'd12, 1'b1);
    chk_a("range", 12, 1, 0, 0, 0, 1);
    chk("range.b_sum", b_sum, 12);
    chk("range.b_rerr", b_rerr, 1);
    chk("range.b_over", b_over, 0);
    handshake("range");

    // saturation on the 6-bit instance
    beats(9, 4'd8); beat(4'd8, 1'b1);
    chk_a("sat", 80, 10, 0, 0, 0, 0);
    chk("sat.b_sum", b_sum, 63);
    chk("sat.b_sat", b_sat, 1);
    chk("sat.b_over", b_over, 1);
    chk("sat.b_beats", b_bc, 10);
    handshake("sat");

    // threshold boundary: 1023 then 1024
    beats(127, 4'd8); beat(4'd7, 1'b1);
    chk_a("th1023", 1023, 128, 0, 0, 0, 0);
    handshake("th1023");
    beats(127, 4'd8); beat(4'd8, 1'b1);
    chk_a("th1024", 1024, 128, 1, 0, 0, 0);
    handshake("th1024");

    // forced close at MAX_BYTES without last
    beats(256, 4'd8);
    chk_a("trunc", 2048, 256, 1, 0, 1, 0);
    chk("trunc.b_sum", b_sum, 63);
    chk("trunc.b_sat", b_sat, 1);
    chk("trunc.b_trunc", b_trunc, 1);
    handshake("trunc");

    // last on exactly the MAX_BYTES beat is not a truncation
    beats(255, 4'd8); beat(4'd8, 1'b1);
    chk_a("maxlast", 2048, 256, 1, 0, 0, 0);
    handshake("maxlast");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
